// File: rtl/ts_pkg.sv
// Shared MPEG-TS definitions: packet constants, PID table entry layout and
// the register pack/unpack helpers used by PID filtering blocks.
package ts_pkg;

  localparam int         TS_PACKET_BYTES = 188;
  localparam logic [7:0] TS_SYNC_BYTE    = 8'h47;

  localparam int PID_W      = 13;
  localparam int PID_LSB    = 0;
  localparam int PID_EN_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_HDR2,
    ST_CAPTURE,
    ST_SKIP
  } ts_state_e;

  typedef struct packed {
    logic             en;
    logic [PID_W-1:0] pid;
  } pid_entry_t;

  function automatic logic [31:0] pid_pack(input pid_entry_t e);
    logic [31:0] w;
    w                     = '0;
    w[PID_LSB +: PID_W]   = e.pid;
    w[PID_EN_BIT]         = e.en;
    return w;
  endfunction

  function automatic pid_entry_t pid_unpack(input logic [31:0] w);
    pid_entry_t e;
    e.pid = w[PID_LSB +: PID_W];
    e.en  = w[PID_EN_BIT];
    return e;
  endfunction

endpackage

// File: rtl/ts_pid_match.sv
// Parallel PID comparators against the whole table with a lowest-index-wins
// priority encoder. Purely combinational.
module ts_pid_match
  import ts_pkg::*;
#(
  parameter int PID_SLOTS = 8,
  parameter int IDX_W     = 3
) (
  input  pid_entry_t [PID_SLOTS-1:0] tbl_i,
  input  logic [PID_W-1:0]           pid_i,
  output logic                       hit_o,
  output logic [IDX_W-1:0]           slot_o
);

  logic [PID_SLOTS-1:0] eq;

  generate
    for (genvar s = 0; s < PID_SLOTS; s++) begin : g_cmp
      assign eq[s] = tbl_i[s].en && (tbl_i[s].pid == pid_i);
    end
  endgenerate

  // Scan downwards so the lowest matching entry is the last assignment.
  always_comb begin
    hit_o  = |eq;
    slot_o = '0;
    for (int s = PID_SLOTS - 1; s >= 0; s--) begin
      if (eq[s]) slot_o = IDX_W'(s);
    end
  end

endmodule

// File: rtl/ts_multi_pid_capture.sv
// TS packet capture: filters a byte stream against a PID table and stores
// matching packets into two ping-pong buffers drained through a word read port.
module ts_multi_pid_capture
  import ts_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PID_SLOTS  = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W     = (PID_SLOTS > 1) ? $clog2(PID_SLOTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  match_enable,
  input  logic                  pid_wr_en,
  input  logic [IDX_W-1:0]      pid_wr_index,
  input  logic [31:0]           pid_wr_data,
  input  logic [IDX_W-1:0]      pid_rd_index,
  output logic [31:0]           pid_rd_data,
  input  logic [7:0]            mpeg_data,
  input  logic                  mpeg_valid,
  input  logic                  mpeg_sync,
  output logic                  pkt_ready,
  output logic [IDX_W-1:0]      pkt_slot,
  input  logic                  rd_en,
  input  logic [7:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  pkt_release,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [CNT_WIDTH-1:0]  sync_err_count
);

  localparam int         BPW        = DATA_WIDTH / 8;
  localparam int         PACK_WORDS = TS_PACKET_BYTES / BPW;
  localparam logic [7:0] LAST_BYTE  = 8'(TS_PACKET_BYTES - 1);

  ts_state_e             state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            hdr1_q;
  pid_entry_t [PID_SLOTS-1:0] tbl_q;
  logic [1:0]            full_q, full_d;
  logic                  head_q, head_d;
  logic                  fill_q, fill_d;
  logic [IDX_W-1:0]      slot_q [2];
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_vld_q;
  logic [7:0]            pkt_mem [2][TS_PACKET_BYTES];

  logic                  hit;
  logic [IDX_W-1:0]      hit_slot;
  logic                  free_any, free_idx;
  logic                  hdr_commit, wr_byte, complete, drop_inc, err_inc, rel;
  logic                  wr_ok, rd_ok, addr_ok;
  logic [7:0]            rd_base;
  logic [DATA_WIDTH-1:0] rd_word;

  ts_pid_match #(
    .PID_SLOTS (PID_SLOTS),
    .IDX_W     (IDX_W)
  ) u_match (
    .tbl_i  (tbl_q),
    .pid_i  ({hdr1_q[4:0], mpeg_data}),
    .hit_o  (hit),
    .slot_o (hit_slot)
  );

  generate
    if (PID_SLOTS == (1 << IDX_W)) begin : g_full_idx
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
    end else begin : g_part_idx
      assign wr_ok = pid_wr_index < IDX_W'(PID_SLOTS);
      assign rd_ok = pid_rd_index < IDX_W'(PID_SLOTS);
    end
  endgenerate

  assign pid_rd_data = rd_ok ? pid_pack(tbl_q[pid_rd_index]) : '0;

  assign pkt_ready = |full_q;
  assign pkt_slot  = pkt_ready ? slot_q[head_q] : '0;
  assign free_any  = ~&full_q;
  assign free_idx  = full_q[0];

  // Stream FSM. A sync byte always terminates the current packet; a good
  // one starts the next packet in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    hdr_commit = 1'b0;
    wr_byte    = 1'b0;
    complete   = 1'b0;
    drop_inc   = 1'b0;
    err_inc    = 1'b0;
    if (mpeg_valid) begin
      if (mpeg_sync) begin
        err_inc = (state_q != ST_IDLE) || (mpeg_data != TS_SYNC_BYTE);
        if (mpeg_data == TS_SYNC_BYTE) begin
          state_d = ST_HDR1;
          cnt_d   = 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        case (state_q)
          ST_HDR1: begin
            state_d = ST_HDR2;
            cnt_d   = 8'd2;
          end
          ST_HDR2: begin
            state_d = ST_SKIP;
            cnt_d   = 8'd3;
            if (hit && match_enable) begin
              if (free_any) begin
                state_d    = ST_CAPTURE;
                fill_d     = free_idx;
                hdr_commit = 1'b1;
              end else begin
                drop_inc = 1'b1;
              end
            end
          end
          ST_CAPTURE, ST_SKIP: begin
            cnt_d   = cnt_q + 8'd1;
            wr_byte = (state_q == ST_CAPTURE);
            if (cnt_q == LAST_BYTE) begin
              state_d  = ST_IDLE;
              complete = (state_q == ST_CAPTURE);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Two-entry packet FIFO over the buffers. While a capture is in flight the
  // fill buffer is free, so release and completion never collide on a slot.
  always_comb begin
    rel    = pkt_release && pkt_ready;
    full_d = full_q;
    head_d = head_q;
    if (rel) begin
      full_d[head_q] = 1'b0;
      head_d         = ~head_q;
    end
    if (complete) begin
      full_d[fill_q] = 1'b1;
      if (!pkt_ready) head_d = fill_q;
    end
  end

  always_comb begin
    drop_d = (drop_inc && !(&drop_q)) ? drop_q + CNT_WIDTH'(1) : drop_q;
    err_d  = (err_inc  && !(&err_q))  ? err_q  + CNT_WIDTH'(1) : err_q;
  end

  always_comb begin
    addr_ok = rd_addr < 8'(PACK_WORDS);
    rd_base = addr_ok ? 8'(rd_addr * BPW) : '0;
    rd_word = '0;
    for (int l = 0; l < BPW; l++) begin
      rd_word[8*l +: 8] = pkt_mem[head_q][rd_base + 8'(l)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hdr1_q    <= '0;
      tbl_q     <= '0;
      full_q    <= '0;
      head_q    <= 1'b0;
      fill_q    <= 1'b0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      drop_q    <= '0;
      err_q     <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      head_q   <= head_d;
      fill_q   <= fill_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      rd_vld_q <= rd_en;
      rd_data_q <= (rd_en && pkt_ready && addr_ok) ? rd_word : '0;
      if (mpeg_valid && !mpeg_sync && state_q == ST_HDR1) hdr1_q <= mpeg_data;
      if (hdr_commit) slot_q[free_idx] <= hit_slot;
      if (pid_wr_en && wr_ok) tbl_q[pid_wr_index] <= pid_unpack(pid_wr_data);
    end
  end

  // Header bytes are held until the filter decision, then written together
  // with byte 2 so a rejected packet never touches a buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hdr_commit) begin
        pkt_mem[free_idx][8'd0] <= TS_SYNC_BYTE;
        pkt_mem[free_idx][8'd1] <= hdr1_q;
        pkt_mem[free_idx][8'd2] <= mpeg_data;
      end
      if (wr_byte) pkt_mem[fill_q][cnt_q] <= mpeg_data;
    end
  end

  assign rd_data        = rd_data_q;
  assign rd_data_valid  = rd_vld_q;
  assign drop_count     = drop_q;
  assign sync_err_count = err_q;

endmodule

// File: tb/tb_ts_multi_pid_capture.sv
// Bench for ts_multi_pid_capture: PID table vectors, directed packet
// sequences and randomized traffic against a packet-level reference model.
module tb_ts_multi_pid_capture;

  localparam int NS  = 8;
  localparam int BPW = 4;
  localparam int PW  = 47;

  logic        clk = 1'b0;
  logic        rst, match_enable, pid_wr_en;
  logic [2:0]  pid_wr_index, pid_rd_index;
  logic [31:0] pid_wr_data, pid_rd_data;
  logic [7:0]  mpeg_data;
  logic        mpeg_valid, mpeg_sync;
  logic        pkt_ready;
  logic [2:0]  pkt_slot;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_data_valid, pkt_release;
  logic [15:0] drop_count, sync_err_count;

  always #5 clk = ~clk;

  ts_multi_pid_capture #(.DATA_WIDTH(32), .PID_SLOTS(NS), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .match_enable(match_enable),
    .pid_wr_en(pid_wr_en), .pid_wr_index(pid_wr_index), .pid_wr_data(pid_wr_data),
    .pid_rd_index(pid_rd_index), .pid_rd_data(pid_rd_data),
    .mpeg_data(mpeg_data), .mpeg_valid(mpeg_valid), .mpeg_sync(mpeg_sync),
    .pkt_ready(pkt_ready), .pkt_slot(pkt_slot),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .pkt_release(pkt_release), .drop_count(drop_count), .sync_err_count(sync_err_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: byte position inside the current packet and a queue of
  // completed packets (188 bytes each) in arrival order.
  int          pos;
  bit          cap;
  int          cur_slot;
  logic [7:0]  cur [188];
  logic [7:0]  q_bytes [$];
  int          q_slot [$];
  logic [15:0] m_drop, m_err;
  logic [12:0] m_pid [NS];
  bit          m_en  [NS];

  bit rnd_mode = 0;
  bit rel_last = 0;
  int rel_div  = 200;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic void m_reset();
    pos = -1; cap = 0; cur_slot = 0;
    q_bytes.delete(); q_slot.delete();
    m_drop = '0; m_err = '0;
    for (int s = 0; s < NS; s++) begin m_pid[s] = '0; m_en[s] = 0; end
  endfunction

  function automatic void m_cycle();
    int n_full;
    bit done;
    int hs;
    n_full = q_slot.size();
    done   = 0;
    if (mpeg_valid) begin
      if (mpeg_sync) begin
        if (pos >= 0 || mpeg_data != 8'h47) m_err = sat(m_err);
        if (mpeg_data == 8'h47) begin pos = 0; cur[0] = mpeg_data; cap = 0; end
        else pos = -1;
      end else if (pos >= 0) begin
        pos++;
        cur[pos] = mpeg_data;
        if (pos == 2) begin
          hs = -1;
          for (int s = NS - 1; s >= 0; s--)
            if (m_en[s] && m_pid[s] == {cur[1][4:0], cur[2]}) hs = s;
          cap = 0;
          if (hs >= 0 && match_enable) begin
            if (n_full < 2) begin cap = 1; cur_slot = hs; end
            else m_drop = sat(m_drop);
          end
        end
        if (pos == 187) begin done = cap; pos = -1; end
      end
    end
    if (pkt_release && n_full > 0) begin
      void'(q_slot.pop_front());
      repeat (188) void'(q_bytes.pop_front());
    end
    if (done) begin
      q_slot.push_back(cur_slot);
      for (int i = 0; i < 188; i++) q_bytes.push_back(cur[i]);
    end
    if (pid_wr_en) begin
      m_pid[pid_wr_index] = pid_wr_data[12:0];
      m_en[pid_wr_index]  = pid_wr_data[16];
    end
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // One clock: model the cycle, advance, compare every observable output.
  task automatic step();
    logic [31:0] ew;
    bit          ev;
    logic [67:0] exp_s, act_s;
    ev = rd_en && !rst;
    ew = '0;
    if (ev && q_slot.size() > 0 && rd_addr < PW)
      for (int l = 0; l < BPW; l++) ew[8*l +: 8] = q_bytes[rd_addr*BPW + l];
    if (rst) m_reset(); else m_cycle();
    @(posedge clk); #1;
    exp_s = {q_slot.size() > 0, (q_slot.size() > 0) ? 3'(q_slot[0]) : 3'd0, m_drop, m_err,
             15'd0, m_en[pid_rd_index], 3'd0, m_pid[pid_rd_index]};
    act_s = {pkt_ready, pkt_slot, drop_count, sync_err_count, pid_rd_data};
    checks++;
    if (act_s !== exp_s) begin
      errors++;
      $display("FAIL status act=%h exp=%h t=%0t", act_s, exp_s, $time);
    end
    checks++;
    if (rd_data_valid !== ev || (ev && rd_data !== ew)) begin
      errors++;
      $display("FAIL rd act=%b/%h exp=%b/%h t=%0t", rd_data_valid, rd_data, ev, ew, $time);
    end
  endtask

  function automatic logic [12:0] rpid();
    case ($urandom_range(0, 5))
      0: return 13'h100;
      1: return 13'h101;
      2: return 13'h102;
      3: return 13'h1FFF;
      4: return 13'h0A0;
      default: return 13'($urandom);
    endcase
  endfunction

  task automatic rand_side();
    rd_en        = ($urandom_range(0, 3) == 0);
    rd_addr      = 8'($urandom_range(0, 50));
    pkt_release  = ($urandom_range(0, rel_div - 1) == 0);
    pid_wr_en    = ($urandom_range(0, 299) == 0);
    pid_wr_index = 3'($urandom);
    pid_wr_data  = $urandom;
    pid_wr_data[12:0] = rpid();
    pid_rd_index = 3'($urandom);
    if ($urandom_range(0, 499) == 0) match_enable = ~match_enable;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit s);
    if (rnd_mode) begin
      while ($urandom_range(0, 3) == 0) begin rand_side(); step(); end
      rand_side();
    end
    mpeg_valid = 1; mpeg_data = d; mpeg_sync = s;
    step();
    mpeg_valid = 0; mpeg_sync = 0;
    if (rnd_mode) begin rd_en = 0; pkt_release = 0; pid_wr_en = 0; end
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [12:0] pid, input int len,
                          input int off, input bit rb);
    logic [7:0] d;
    for (int n = 0; n < len; n++) begin
      if (n == 0)      d = b0;
      else if (n == 1) d = {rb ? 3'($urandom) : 3'd0, pid[12:8]};
      else if (n == 2) d = pid[7:0];
      else             d = rb ? 8'($urandom) : 8'(n + off);
      if (n == len - 1 && rel_last) pkt_release = 1;
      send_byte(d, n == 0);
      if (!rnd_mode) pkt_release = 0;
    end
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] w);
    rd_en = 1; rd_addr = a;
    step();
    rd_en = 0;
    w = rd_data;
  endtask

  task automatic do_release();
    pkt_release = 1; step(); pkt_release = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0; step();
  endtask

  task automatic wr_pid(input logic [2:0] i, input logic [31:0] d);
    pid_wr_en = 1; pid_wr_index = i; pid_wr_data = d;
    step();
    pid_wr_en = 0;
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  wi;
    logic [31:0] wd;
    logic [2:0]  ri;
    logic [31:0] exp;
  } pv_t;

  initial begin
    pv_t         pv [8];
    logic [31:0] w;

    pv[0] = '{1, 3'd0, 32'h0001_1FFF, 3'd0, 32'h0001_1FFF};
    pv[1] = '{1, 3'd1, 32'hFFFE_E123, 3'd1, 32'h0000_0123};
    pv[2] = '{1, 3'd2, 32'h0003_0042, 3'd2, 32'h0001_0042};
    pv[3] = '{0, 3'd0, 32'h0000_0000, 3'd1, 32'h0000_0123};
    pv[4] = '{1, 3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0001_1FFF};
    pv[5] = '{0, 3'd0, 32'h0000_0000, 3'd3, 32'h0000_0000};
    pv[6] = '{1, 3'd0, 32'h0000_0000, 3'd0, 32'h0000_0000};
    pv[7] = '{0, 3'd0, 32'h0000_0000, 3'd2, 32'h0001_0042};

    rst = 1; match_enable = 1; pid_wr_en = 0; pid_wr_index = 0; pid_wr_data = 0;
    pid_rd_index = 0; mpeg_data = 0; mpeg_valid = 0; mpeg_sync = 0;
    rd_en = 0; rd_addr = 0; pkt_release = 0;
    step(); rst = 0; step();
    chk("rst_ready", {31'd0, pkt_ready}, 0);
    chk("rst_counts", {drop_count, sync_err_count}, 0);
    chk("rst_pidrd", pid_rd_data, 0);

    for (int i = 0; i < 8; i++) begin
      pid_wr_en = pv[i].we; pid_wr_index = pv[i].wi; pid_wr_data = pv[i].wd;
      pid_rd_index = pv[i].ri;
      step();
      pid_wr_en = 0;
      chk($sformatf("pidtab%0d", i), pid_rd_data, pv[i].exp);
    end
    pid_rd_index = 0;

    // Single packet, slot 3, byte n = n.
    do_reset();
    wr_pid(3, 32'h0001_0100);
    send_pkt(8'h47, 13'h100, 188, 0, 0);
    chk("t1_ready", {31'd0, pkt_ready}, 1);
    chk("t1_slot", {29'd0, pkt_slot}, 3);
    do_read(1, w);  chk("t1_w1", w, 32'h0706_0504);
    do_read(0, w);  chk("t1_w0", w, 32'h0300_0147);
    do_read(46, w); chk("t1_w46", w, 32'hBBBA_B9B8);

    // Three packets, no free buffer for the third.
    do_release();
    chk("t2_empty", {31'd0, pkt_ready}, 0);
    send_pkt(8'h47, 13'h100, 188, 8'h10, 0);
    send_pkt(8'h47, 13'h100, 188, 8'h20, 0);
    send_pkt(8'h47, 13'h100, 188, 8'h30, 0);
    chk("t2_drop", {16'd0, drop_count}, 1);
    do_read(1, w); chk("t2_p1w1", w, 32'h1716_1514);
    do_read(0, w); chk("t2_p1w0", w, 32'h1300_0147);
    do_release();
    do_read(1, w); chk("t2_p2w1", w, 32'h2726_2524);
    do_release();
    chk("t2_drained", {31'd0, pkt_ready}, 0);

    // Bad sync byte, then truncation followed by a good packet.
    do_reset();
    send_pkt(8'h48, 13'h100, 188, 0, 0);
    chk("t3_err", {16'd0, sync_err_count}, 1);
    chk("t3_nocap", {31'd0, pkt_ready}, 0);
    do_reset();
    wr_pid(3, 32'h0001_0100);
    send_pkt(8'h47, 13'h100, 100, 8'h40, 0);
    send_pkt(8'h47, 13'h100, 188, 8'h50, 0);
    chk("t3_trunc_err", {16'd0, sync_err_count}, 1);
    chk("t3_ready", {31'd0, pkt_ready}, 1);
    do_read(1, w); chk("t3_w1", w, 32'h5756_5554);

    // Priority, disabled entry, global enable off.
    do_reset();
    wr_pid(0, 32'h0001_1FFF);
    wr_pid(5, 32'h0001_1FFF);
    send_pkt(8'h47, 13'h1FFF, 188, 0, 0);
    chk("t4_slot0", {29'd0, pkt_slot}, 0);
    do_release();
    wr_pid(0, 32'h0000_1FFF);
    send_pkt(8'h47, 13'h1FFF, 188, 0, 0);
    chk("t4_slot5", {29'd0, pkt_slot}, 5);
    do_release();
    match_enable = 0;
    send_pkt(8'h47, 13'h1FFF, 188, 0, 0);
    chk("t4_me_off", {31'd0, pkt_ready}, 0);
    chk("t4_drop", {16'd0, drop_count}, 0);
    match_enable = 1;

    // Release coinciding with completion of the next packet.
    send_pkt(8'h47, 13'h1FFF, 188, 8'h60, 0);
    rel_last = 1;
    send_pkt(8'h47, 13'h1FFF, 188, 8'h70, 0);
    rel_last = 0;
    chk("t5_ready", {31'd0, pkt_ready}, 1);
    do_read(1, w); chk("t5_w1", w, 32'h7776_7574);
    do_read(47, w); chk("t5_oob", w, 0);
    chk("t5_oob_vld", {31'd0, rd_data_valid}, 1);
    do_release();
    chk("t5_one_left", {31'd0, pkt_ready}, 0);

    // Reset mid-capture clears state and the table.
    do_reset();
    wr_pid(2, 32'h0001_0ABC);
    send_byte(8'h48, 1);
    send_pkt(8'h47, 13'h0ABC, 188, 0, 0);
    send_pkt(8'h47, 13'h0ABC, 50, 0, 0);
    pid_rd_index = 2;
    do_reset();
    chk("t6_ready", {31'd0, pkt_ready}, 0);
    chk("t6_counts", {drop_count, sync_err_count}, 0);
    chk("t6_tbl", pid_rd_data, 0);
    send_pkt(8'h47, 13'h0ABC, 188, 0, 0);
    chk("t6_ignored", {31'd0, pkt_ready}, 0);
    wr_pid(2, 32'h0001_0ABC);
    send_pkt(8'h47, 13'h0ABC, 188, 0, 0);
    chk("t6_recap", {28'd0, pkt_ready, pkt_slot}, 32'hA);
    pid_rd_index = 0;

    // Randomized traffic with gaps, reads, releases and table updates.
    do_reset();
    for (int s = 0; s < NS; s++) wr_pid(3'(s), {15'd0, 1'($urandom), 3'd0, rpid()});
    rnd_mode = 1;
    for (int ph = 0; ph < 4; ph++) begin
      rel_div = (ph % 2) ? 60 : 1500;
      for (int p = 0; p < 15; p++) begin
        int kind;
        kind = $urandom_range(0, 9);
        if (kind == 0)
          send_pkt(($urandom_range(0, 1) == 0) ? 8'h48 : 8'($urandom_range(0, 70)), rpid(), 188, 0, 1);
        else if (kind == 1)
          send_pkt(8'h47, rpid(), $urandom_range(1, 187), 0, 1);
        else
          send_pkt(8'h47, rpid(), 188, 0, 1);
      end
    end
    rnd_mode = 0;
    rd_en = 0; pkt_release = 0; pid_wr_en = 0; match_enable = 1;
    for (int k = 0; k < 3 && pkt_ready; k++) begin
      for (int a = 0; a < PW; a++) do_read(8'(a), w);
      do_release();
    end
    chk("drain_empty", {31'd0, pkt_ready}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
